// File: rtl/uart_cmd_processor.sv
// UART-controlled command processor: serial frames drive register-file writes/reads
// and a 16-bit ALU whose results go back out on the serial TX line.
module uart_cmd_processor #(
   parameter int WIDTH        = 8,
   parameter int RF_ADDR_W    = 4,
   parameter int ALU_FUN_W    = 4,
   parameter int CLKS_PER_BIT = 40
) (
   input  logic i_ref_clk,
   input  logic i_rst,
   input  logic i_rx,
   output logic o_tx
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   // ---------------- RX ----------------
   logic             rx_s1, rx_s2, rx_q;
   logic             rx_busy;
   logic [CW-1:0]    rx_cnt;
   logic [3:0]       rx_idx;
   logic [WIDTH:0]   rx_sh;
   logic             rx_valid;
   logic [WIDTH-1:0] rx_data;

   always_ff @(posedge i_ref_clk or negedge i_rst) begin
      if (!i_rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_q     <= 1'b1;
         rx_busy  <= 1'b0;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_sh    <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_s1    <= i_rx;
         rx_s2    <= rx_s1;
         rx_q     <= rx_s2;
         rx_valid <= 1'b0;
         if (!rx_busy) begin
            if (rx_q && !rx_s2) begin
               rx_busy <= 1'b1;
               rx_cnt  <= '0;
               rx_idx  <= '0;
            end
         end else if (rx_cnt == ((rx_idx == 4'd0) ? HALF : LAST)) begin
            // first wait is half a bit so every later sample lands mid-bit
            rx_cnt <= '0;
            rx_idx <= rx_idx + 4'd1;
            if (rx_idx == 4'd0) begin
               if (rx_s2) rx_busy <= 1'b0;
            end else if (rx_idx <= 4'd9) begin
               rx_sh <= {rx_s2, rx_sh[WIDTH:1]};
            end else begin
               rx_busy <= 1'b0;
               if (rx_s2 && !(^rx_sh)) begin
                  rx_valid <= 1'b1;
                  rx_data  <= rx_sh[WIDTH-1:0];
               end
            end
         end else begin
            rx_cnt <= rx_cnt + 1'b1;
         end
      end
   end

   // ---------------- TX ----------------
   logic             tx_busy;
   logic [CW-1:0]    tx_cnt;
   logic [3:0]       tx_idx;
   logic [WIDTH+2:0] tx_sh;
   logic             tx_last, tx_ready, tx_start;
   logic [WIDTH-1:0] tx_byte;

   // the final cycle of a stop bit counts as idle so frames can run back-to-back
   assign tx_last  = tx_busy && (tx_cnt == LAST) && (tx_idx == 4'd10);
   assign tx_ready = !tx_busy || tx_last;
   assign o_tx     = tx_busy ? tx_sh[0] : 1'b1;

   always_ff @(posedge i_ref_clk or negedge i_rst) begin
      if (!i_rst) begin
         tx_busy <= 1'b0;
         tx_cnt  <= '0;
         tx_idx  <= '0;
         tx_sh   <= '1;
      end else if (tx_start && tx_ready) begin
         tx_busy <= 1'b1;
         tx_cnt  <= '0;
         tx_idx  <= '0;
         tx_sh   <= {1'b1, ^tx_byte, tx_byte, 1'b0};
      end else if (tx_busy) begin
         if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 4'd10) begin
               tx_busy <= 1'b0;
            end else begin
               tx_idx <= tx_idx + 4'd1;
               tx_sh  <= {1'b1, tx_sh[WIDTH+2:1]};
            end
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

   // ---------------- register file / ALU ----------------
   logic [WIDTH-1:0]     rf [0:(1<<RF_ADDR_W)-1];
   logic [RF_ADDR_W-1:0] addr;
   logic [ALU_FUN_W-1:0] func;
   logic [RW-1:0]        snd_buf;
   logic [1:0]           snd_left;
   logic [RW-1:0]        a_x, b_x, alu_res;

   assign a_x = {{WIDTH{1'b0}}, rf[0]};
   assign b_x = {{WIDTH{1'b0}}, rf[1]};

   always_comb begin
      alu_res = '0;
      case (32'(func))
         0:  alu_res = a_x + b_x;
         1:  alu_res = a_x - b_x;
         2:  alu_res = a_x * b_x;
         3:  alu_res = (rf[1] == '0) ? '0 : a_x / b_x;
         4:  alu_res = a_x & b_x;
         5:  alu_res = a_x | b_x;
         6:  alu_res = {{WIDTH{1'b0}}, ~(rf[0] & rf[1])};
         7:  alu_res = {{WIDTH{1'b0}}, ~(rf[0] | rf[1])};
         8:  alu_res = a_x ^ b_x;
         9:  alu_res = {{WIDTH{1'b0}}, ~(rf[0] ^ rf[1])};
         10: alu_res = (rf[0] == rf[1]) ? RW'(1) : '0;
         11: alu_res = (rf[0] >  rf[1]) ? RW'(2) : '0;
         12: alu_res = (rf[0] <  rf[1]) ? RW'(3) : '0;
         13: alu_res = a_x >> 1;
         14: alu_res = a_x << 1;
         default: alu_res = '0;
      endcase
   end

   // ---------------- command FSM ----------------
   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUNC, EXEC, SEND
   } state_t;
   state_t state_q, state_d;

   always_ff @(posedge i_ref_clk or negedge i_rst) begin
      if (!i_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tx_start = 1'b0;
      tx_byte  = snd_buf[WIDTH-1:0];
      case (state_q)
         IDLE: if (rx_valid) begin
            case (rx_data)
               8'hAA:   state_d = WR_ADDR;
               8'hBB:   state_d = RD_ADDR;
               8'hCC:   state_d = OP_A;
               8'hDD:   state_d = FUNC;
               default: state_d = IDLE;
            endcase
         end
         WR_ADDR: if (rx_valid) state_d = WR_DATA;
         WR_DATA: if (rx_valid) state_d = IDLE;
         RD_ADDR: if (rx_valid) state_d = SEND;
         OP_A:    if (rx_valid) state_d = OP_B;
         OP_B:    if (rx_valid) state_d = FUNC;
         FUNC:    if (rx_valid) state_d = EXEC;
         EXEC:    state_d = SEND;
         SEND: begin
            if (snd_left != 2'd0) tx_start = tx_ready;
            else if (tx_last)     state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_ref_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < (1 << RF_ADDR_W); i++) rf[i] <= '0;
         addr     <= '0;
         func     <= '0;
         snd_buf  <= '0;
         snd_left <= '0;
      end else begin
         case (state_q)
            WR_ADDR: if (rx_valid) addr <= rx_data[RF_ADDR_W-1:0];
            WR_DATA: if (rx_valid) rf[addr] <= rx_data;
            RD_ADDR: if (rx_valid) begin
               snd_buf  <= {{WIDTH{1'b0}}, rf[rx_data[RF_ADDR_W-1:0]]};
               snd_left <= 2'd1;
            end
            OP_A:    if (rx_valid) rf[0] <= rx_data;
            OP_B:    if (rx_valid) rf[1] <= rx_data;
            FUNC:    if (rx_valid) func <= rx_data[ALU_FUN_W-1:0];
            EXEC: begin
               snd_buf  <= alu_res;
               snd_left <= 2'd2;
            end
            SEND: if (tx_start && tx_ready) begin
               snd_buf  <= snd_buf >> WIDTH;
               snd_left <= snd_left - 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_processor.sv
// Bench for uart_cmd_processor: command vectors drive RX, a TX decoder checks
// each returned frame against a queue of expected bytes.
module tb_uart_cmd_processor;

   localparam int CPB   = 16;
   localparam int LIMIT = 40 * 11 * CPB;

   logic clk = 1'b0;
   logic rst_n;
   logic rx;
   logic tx;

   int checks = 0;
   int passes = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [31:0] bytes;  // sent MSB byte first
      int          n;
      logic [15:0] exp;    // low byte returned first
      int          ne;
   } vec_t;
   vec_t vecs[$];

   always #10 clk = ~clk;

   uart_cmd_processor #(.CLKS_PER_BIT(CPB)) dut (
      .i_ref_clk(clk),
      .i_rst(rst_n),
      .i_rx(rx),
      .o_tx(tx)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_par);
      logic [10:0] fr;
      fr = {1'b1, (^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx = fr[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic wait_resp();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < LIMIT) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL resp_timeout: got %0d frames outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic push_exp(input logic [15:0] e, input int ne);
      if (ne > 0) exp_q.push_back(e[7:0]);
      if (ne > 1) exp_q.push_back(e[15:8]);
   endtask

   // TX frame decoder / scoreboard
   initial begin
      logic [7:0] d;
      logic [7:0] e;
      logic st, p, sp;
      forever begin
         @(negedge tx);
         repeat (CPB / 2) @(negedge clk);
         st = tx;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         p = tx;
         repeat (CPB) @(negedge clk);
         sp = tx;
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_frame: got data %02h, required no frame", d);
         end else begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(d), 32'(e));
            chk("tx_framing", 32'({st, p, sp}), 32'({1'b0, ^e, 1'b1}));
         end
      end
   end

   initial begin
      int lows;
      vecs.push_back('{32'hAA053C00, 3, 16'h0000, 0});
      vecs.push_back('{32'hBB050000, 2, 16'h003C, 1});
      vecs.push_back('{32'hCC070300, 4, 16'h000A, 2});
      vecs.push_back('{32'hDD020000, 2, 16'h0015, 2});
      vecs.push_back('{32'hCC090003, 4, 16'h0000, 2});
      vecs.push_back('{32'hDD010000, 2, 16'h0009, 2});
      vecs.push_back('{32'hDD0B0000, 2, 16'h0002, 2});
      vecs.push_back('{32'hDD0C0000, 2, 16'h0000, 2});
      vecs.push_back('{32'hDD0D0000, 2, 16'h0004, 2});
      vecs.push_back('{32'hDD0E0000, 2, 16'h0012, 2});
      vecs.push_back('{32'hDD060000, 2, 16'h00FF, 2});
      vecs.push_back('{32'hDD070000, 2, 16'h00F6, 2});
      vecs.push_back('{32'hDD0A0000, 2, 16'h0000, 2});
      vecs.push_back('{32'hDD0F0000, 2, 16'h0000, 2});
      vecs.push_back('{32'hCCFFFF02, 4, 16'hFE01, 2});
      vecs.push_back('{32'hCC030501, 4, 16'hFFFE, 2});
      vecs.push_back('{32'hCC05050A, 4, 16'h0001, 2});
      vecs.push_back('{32'hCC80000E, 4, 16'h0100, 2});
      vecs.push_back('{32'hCCF00F08, 4, 16'h00FF, 2});
      vecs.push_back('{32'hCCF00F09, 4, 16'h0000, 2});
      vecs.push_back('{32'hCC640703, 4, 16'h000E, 2});
      vecs.push_back('{32'hCC02030C, 4, 16'h0003, 2});
      vecs.push_back('{32'hCCC86400, 4, 16'h012C, 2});
      vecs.push_back('{32'hCC0C0A04, 4, 16'h0008, 2});
      vecs.push_back('{32'hCC0C0A05, 4, 16'h000E, 2});
      vecs.push_back('{32'h55BB0500, 3, 16'h003C, 1});
      vecs.push_back('{32'hAA0F7700, 3, 16'h0000, 0});
      vecs.push_back('{32'hBB0F0000, 2, 16'h0077, 1});
      vecs.push_back('{32'hAA1F6600, 3, 16'h0000, 0});
      vecs.push_back('{32'hBB0F0000, 2, 16'h0066, 1});

      rx    = 1'b1;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_tx_idle", 32'(tx), 32'd1);
      rst_n = 1'b1;

      // idle line for two frame times must produce nothing
      lows = 0;
      for (int i = 0; i < 22 * CPB; i++) begin
         @(negedge clk);
         if (!tx) lows++;
      end
      chk("idle_no_frame", 32'(lows), 32'd0);

      for (int v = 0; v < vecs.size(); v++) begin
         push_exp(vecs[v].exp, vecs[v].ne);
         for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].bytes[31-8*k -: 8], 1'b0);
         wait_resp();
      end

      // a write command with bad parity is dropped; the read that follows is honoured
      send_byte(8'hAA, 1'b1);
      push_exp(16'h003C, 1);
      send_byte(8'hBB, 1'b0);
      send_byte(8'h05, 1'b0);
      wait_resp();

      // reset in the middle of a CC command and mid-frame
      send_byte(8'hCC, 1'b0);
      send_byte(8'h11, 1'b0);
      rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_mid_tx_idle", 32'(tx), 32'd1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      push_exp(16'h0000, 1);
      send_byte(8'hBB, 1'b0);
      send_byte(8'h00, 1'b0);
      wait_resp();
      push_exp(16'h0000, 1);
      send_byte(8'hBB, 1'b0);
      send_byte(8'h05, 1'b0);
      wait_resp();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_cmd_processor.md
Name: uart_cmd_processor

Overview:
- Single-clock UART-controlled processing unit: receives command frames on a serial RX line, executes register-file writes/reads and ALU operations, and returns results on a serial TX line.
- Sits at system top level between the external UART pins and the internal register file and ALU.

Parameters:
- WIDTH, 8, data/operand width and UART payload width.
- RF_ADDR_W, 4, register-file address width (16 entries).
- ALU_FUN_W, 4, ALU function code width.
- CLKS_PER_BIT, 40, i_ref_clk cycles per UART bit (800 ns bit at 20 ns clock).

Ports:
- i_ref_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_rx  input  1  UART serial input; idle high.
- o_tx  output  1  UART serial output; idle high.

Behaviour:
- Frame format, both directions: start bit 0, 8 data bits LSB first, parity bit = XOR of data bits (even parity), stop bit 1. 11 bit periods.
- RX:
  - Double-flop synchronize i_rx.
  - Falling edge while idle starts a frame; bits are sampled at mid-bit (CLKS_PER_BIT/2 after each bit start).
  - Start bit re-checked at mid-bit; if high, abort to idle.
  - Parity or stop error: byte discarded, no strobe.
  - A good byte produces a one-cycle rx_valid strobe internally.
- Command FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUNC, EXEC, SEND.
  - 0xAA, RF write: next byte is the address (low RF_ADDR_W bits used), next byte is the data; write RF[addr]. No response.
  - 0xBB, RF read: next byte is the address; transmit RF[addr] as one frame.
  - 0xCC, ALU with operands: next bytes op A -> RF[0] and op B -> RF[1], then func; compute and send result.
  - 0xDD, ALU no-operand: next byte is func; uses current RF[0] and RF[1]; compute and send result.
  - Any other byte in IDLE: ignored.
  - Bytes received while in SEND are dropped.
- ALU result is 16 bits, computed in EXEC in one cycle, A = RF[0], B = RF[1].
- ALU function codes:
  - 0 add; 1 sub (A-B, two's complement, 16-bit wrap); 2 mul; 3 div (B=0 gives 0).
  - 4 and; 5 or; 6 nand; 7 nor; 8 xor; 9 xnor (logic ops zero-extended to 16 bits).
  - 10 eq gives 1/0; 11 gt gives 2/0; 12 lt gives 3/0.
  - 13 A>>1; 14 A<<1.
  - 15 gives 0.
- ALU response: two frames, low byte then high byte, back-to-back (next start bit immediately after stop).
- TX:
  - Accepts a byte only when idle.
  - Holds o_tx = 1 between transmissions.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- After the last response frame's stop bit completes, the FSM returns to IDLE.
- Reset, async: o_tx = 1; FSM in IDLE; RX and TX idle; all RF entries 0. Asserting reset mid-frame or mid-command aborts everything immediately.

Test Plan:
- Reset asserted then released, i_rx held high for 2 frame times -> o_tx stays 1, no frames emitted.
- Send 0xAA, 0x05, 0x3C, then 0xBB, 0x05 -> one TX frame: data 0x3C, parity 0, stop 1.
- Send 0xCC, 0x07, 0x03, 0x00 -> TX frames 0x0A then 0x00; then 0xDD, 0x02 -> 0x15, 0x00 (7*3).
- Send 0xCC, 0x09, 0x00, 0x03 -> divide by zero -> frames 0x00, 0x00. Then 0xDD, 0x01 -> 0x09, 0x00.
- Send 0xAA frame with wrong parity, then 0xBB, 0x05 -> wrong-parity byte ignored; read returns the previously written value, and no stray write occurs.
- Assert reset midway through the 0xCC sequence, then send 0xBB, 0x00 -> returns 0x00 (RF cleared); o_tx = 1 during reset.
